// File: rtl/vesp_prog_loader.sv
// Program loader for the vesp1 core: holds the CPU in reset, zeroes low memory,
// streams instruction words into main memory from a base address, then releases the CPU.
module vesp_prog_loader #(
    parameter int unsigned word_size    = 16,
    parameter int unsigned address_size = 12,
    parameter int unsigned clear_depth  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [address_size-1:0] base_addr,
    input  logic [word_size-1:0]    in_word,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [address_size-1:0] mem_addr,
    output logic [word_size-1:0]    mem_wdata,
    output logic                    mem_we,
    output logic                    cpu_rst,
    output logic                    busy,
    output logic                    done,
    output logic [address_size:0]   word_count
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StFinish,
        StRun
    } state_e;

    localparam logic [address_size-1:0] ClearLast = address_size'(clear_depth - 1);
    localparam logic [address_size:0]   CountMax  = {1'b1, {address_size{1'b0}}};

    state_e                  state_q, state_d;
    logic [address_size-1:0] base_q, base_d;
    logic [address_size-1:0] mem_addr_q, mem_addr_d;
    logic [word_size-1:0]    mem_wdata_q, mem_wdata_d;
    logic                    mem_we_q, mem_we_d;
    logic                    in_ready_q, in_ready_d;
    logic                    cpu_rst_q, cpu_rst_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [address_size:0]   word_count_q, word_count_d;

    logic handshake;
    assign handshake = in_valid & in_ready_q;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        in_ready_d   = in_ready_q;
        cpu_rst_d    = cpu_rst_q;
        busy_d       = busy_q;
        done_d       = done_q;
        word_count_d = word_count_q;

        unique case (state_q)
            StIdle, StRun: begin
                in_ready_d = 1'b0;
                if (start) begin
                    // The first clear write (address 0) goes out on the same edge.
                    state_d      = StClear;
                    base_d       = base_addr;
                    word_count_d = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    cpu_rst_d    = 1'b0;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = '0;
                    mem_wdata_d  = '0;
                end
            end
            StClear: begin
                if (mem_addr_q == ClearLast) begin
                    in_ready_d = 1'b1;
                    state_d    = StLoad;
                end else begin
                    mem_addr_d  = mem_addr_q + address_size'(1);
                    mem_wdata_d = '0;
                    mem_we_d    = 1'b1;
                end
            end
            StLoad: begin
                if (handshake) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_q + word_count_q[address_size-1:0];
                    mem_wdata_d = in_word;
                    if (word_count_q != CountMax) begin
                        word_count_d = word_count_q + (address_size + 1)'(1);
                    end
                    if (in_last) begin
                        in_ready_d = 1'b0;
                        state_d    = StFinish;
                    end
                end
            end
            StFinish: begin
                cpu_rst_d = 1'b1;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = StRun;
            end
            default: begin
                state_d    = StIdle;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b0;
                cpu_rst_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            base_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            in_ready_q   <= 1'b0;
            cpu_rst_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            in_ready_q   <= in_ready_d;
            cpu_rst_q    <= cpu_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            word_count_q <= word_count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_vesp_prog_loader.sv
// Bench for vesp_prog_loader: directed and randomized programs checked against a
// memory-image reference model kept in the bench.
module tb_vesp_prog_loader;

    localparam int AW = 12;
    localparam int WW = 16;
    localparam int CD = 256;
    localparam int MS = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [WW-1:0] in_word = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          mem_we;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;

    int total = 0;
    int passed = 0;
    int fails = 0;

    logic [WW-1:0] mem     [MS];
    logic [WW-1:0] ref_mem [MS];
    logic [AW-1:0] wlog[$];
    logic [WW-1:0] prog[$];

    always #5 clk = ~clk;

    vesp_prog_loader #(
        .word_size   (WW),
        .address_size(AW),
        .clear_depth (CD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .word_count(word_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; the bench memory captures writes.
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) begin
            mem[mem_addr] = mem_wdata;
            wlog.push_back(mem_addr);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, {27'd0, cpu_rst, mem_we, in_ready, busy, done}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_count"}, word_count, 32'd0);
    endtask

    // Runs a complete start/clear/load/release sequence for the words in prog.
    task automatic load_prog(input logic [AW-1:0] base, input int min_idle, input int max_idle,
                             input bit poke);
        int k;
        int nbad;
        int nmis;
        int idle;
        for (int a = 0; a < CD; a++) ref_mem[a] = '0;
        for (int i = 0; i < prog.size(); i++) ref_mem[(int'(base) + i) % MS] = prog[i];

        base_addr = base;
        start = 1'b1;
        wlog.delete();
        step();
        start = 1'b0;
        base_addr = AW'($urandom);
        chk("start_busy", busy, 32'd1);
        chk("start_cpu_held", cpu_rst, 32'd0);
        chk("start_done", done, 32'd0);
        chk("start_ready", in_ready, 32'd0);

        k = 0;
        while (in_ready !== 1'b1 && k < 400) begin
            step();
            k++;
        end
        chk("clear_len", k, CD);
        chk("clear_writes", wlog.size(), CD);
        nbad = 0;
        for (int i = 0; i < wlog.size(); i++) if (int'(wlog[i]) != i) nbad++;
        chk("clear_order", nbad, 32'd0);
        nbad = 0;
        for (int a = 0; a < CD; a++) if (mem[a] !== '0) nbad++;
        chk("clear_zero", nbad, 32'd0);
        chk("clear_we_off", mem_we, 32'd0);

        for (int i = 0; i < prog.size(); i++) begin
            idle = $urandom_range(max_idle, min_idle);
            repeat (idle) begin
                in_valid = 1'b0;
                in_word = WW'($urandom);
                if (poke) start = 1'b1;
                step();
                start = 1'b0;
                chk("idle_we", mem_we, 32'd0);
                chk("idle_ready", in_ready, 32'd1);
            end
            in_word = prog[i];
            in_last = (i == prog.size() - 1);
            in_valid = 1'b1;
            step();
            chk("wr_we", mem_we, 32'd1);
            chk("wr_addr", mem_addr, (int'(base) + i) % MS);
            chk("wr_data", mem_wdata, prog[i]);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("fin_cpu_held", cpu_rst, 32'd0);
        chk("fin_ready_low", in_ready, 32'd0);
        step();
        chk("run_cpu_rst", cpu_rst, 32'd1);
        chk("run_done", done, 32'd1);
        chk("run_busy", busy, 32'd0);
        chk("run_we", mem_we, 32'd0);
        chk("run_count", word_count, prog.size());
        step();
        chk("run_idle", {30'd0, in_ready, mem_we}, 32'd0);
        chk("run_stable", cpu_rst, 32'd1);

        nmis = 0;
        for (int a = 0; a < MS; a++) if (mem[a] !== ref_mem[a]) nmis++;
        chk("mem_image", nmis, 32'd0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int a = 0; a < MS; a++) begin
            mem[a] = 16'hDEAD;
            ref_mem[a] = 16'hDEAD;
        end

        // Reset state
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b1;
        step();
        check_reset_vals("post_reset");

        // Directed program at base 2
        prog = '{16'h2000, 16'h0008, 16'h2001, 16'h000B, 16'h0000, 16'h7000};
        load_prog(AW'(2), 0, 0, 1'b0);

        // Stalls: in_valid toggles, base 0x10
        prog.delete();
        repeat (4) prog.push_back(WW'($urandom));
        load_prog(AW'('h10), 1, 1, 1'b0);

        // Address wrap
        prog.delete();
        repeat (4) prog.push_back(WW'($urandom));
        load_prog(AW'('hFFE), 0, 1, 1'b0);

        // Reset mid-LOAD after 3 words
        base_addr = AW'('h40);
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (in_ready !== 1'b1 && k < 400) begin
            step();
            k++;
        end
        chk("abort_clear_len", k, CD);
        for (int i = 0; i < 3; i++) begin
            in_word = WW'($urandom);
            in_valid = 1'b1;
            step();
        end
        chk("abort_count", word_count, 32'd3);
        in_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        check_reset_vals("async_reset");
        step();
        check_reset_vals("held_reset");
        rst = 1'b1;
        step();
        check_reset_vals("after_abort");
        prog.delete();
        repeat (8) prog.push_back(WW'($urandom));
        load_prog(AW'('h40), 0, 1, 1'b0);

        // Restart from RUN with start pulses poked during LOAD
        prog.delete();
        repeat (5) prog.push_back(WW'($urandom));
        load_prog(AW'('h123), 1, 2, 1'b1);

        // Randomized programs
        for (int r = 0; r < 4; r++) begin
            prog.delete();
            repeat ($urandom_range(24, 1)) prog.push_back(WW'($urandom));
            load_prog(AW'($urandom), 0, 2, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
